// File: rtl/uart_receiver_if.sv
// Byte handshake between the UART receiver and the register block.
// The receiver drives the byte and its valid flag; the consumer drives ready.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling on a run-time divisor,
// single-entry holding register with framing-error and overrun pulses.
module uart_receiver #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned MIN_BDRT   = 9_600,
  parameter int unsigned BAUD_BITS  = $clog2((CLOCK_FREQ + (MIN_BDRT / 2) - 1) / (MIN_BDRT / 2))
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BAUD_BITS-1:0] baud_edge,
  input  logic                 serial_in,
  uart_receiver_if.master      rx_if,
  output logic                 rx_busy,
  output logic                 framing_error,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_q,   state_d;
  logic [1:0]           sync_q,    sync_d;
  logic [BAUD_BITS-1:0] cnt_q,     cnt_d;
  logic [2:0]           bit_q,     bit_d;
  logic [7:0]           shift_q,   shift_d;
  logic                 deliver_q, deliver_d;
  logic [7:0]           data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 busy_q,    busy_d;
  logic                 ferr_q,    ferr_d;
  logic                 ovr_q,     ovr_d;

  logic                 rx_s;
  logic [BAUD_BITS-1:0] half;
  logic                 consume;

  assign rx_s    = sync_q[1];
  assign half    = baud_edge >> 1;
  assign consume = valid_q & rx_if.data_out_ready;

  // Next-state: frame FSM, bit counters and holding-register update.
  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[0], serial_in};
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    deliver_d = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == half) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + BAUD_BITS'(1);
        end
      end
      DATA: begin
        if (cnt_q == baud_edge) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + BAUD_BITS'(1);
        end
      end
      STOP: begin
        if (cnt_q == baud_edge) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + BAUD_BITS'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = (cnt_q == baud_edge) ? '0 : cnt_q + BAUD_BITS'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A pending byte lands only if the slot is empty or being drained this cycle.
    if (deliver_q) begin
      if (!valid_q || consume) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      deliver_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      deliver_q <= deliver_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_if.data_out       = data_q;
  assign rx_if.data_out_valid = valid_q;
  assign rx_busy              = busy_q;
  assign framing_error        = ferr_q;
  assign overrun              = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: table of single frames plus hand-written corner sequences,
// with an expected-byte queue checked against bytes captured at each handshake.
module tb_uart_receiver;

  localparam int unsigned BB = 15;

  logic          clk;
  logic          rst_n;
  logic [BB-1:0] baud;
  logic          serial_in;
  logic          rx_busy;
  logic          ferr;
  logic          ovr;

  uart_receiver_if rx_if ();

  uart_receiver #(
    .CLOCK_FREQ(125_000_000),
    .MIN_BDRT  (9_600),
    .BAUD_BITS (BB)
  ) dut (
    .clk          (clk),
    .reset_n      (rst_n),
    .baud_edge    (baud),
    .serial_in    (serial_in),
    .rx_if        (rx_if),
    .rx_busy      (rx_busy),
    .framing_error(ferr),
    .overrun      (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor-owned observations
  logic [7:0] got_mem [64];
  int got_wr   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int vhi_cnt  = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  logic vprev  = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.data_out_valid && rx_if.data_out_ready) begin
        got_mem[got_wr % 64] = rx_if.data_out;
        got_wr = got_wr + 1;
      end
      if (ferr) ferr_cnt = ferr_cnt + 1;
      if (ovr) ovr_cnt = ovr_cnt + 1;
      if (rx_if.data_out_valid) vhi_cnt = vhi_cnt + 1;
      if (rx_if.data_out_valid && !vprev) begin
        rise_cnt = rise_cnt + 1;
        rise_cyc = cyc;
      end
    end
    vprev = rx_if.data_out_valid;
  end

  // Main-owned state
  int n_tests = 0;
  int n_fail  = 0;
  int got_rd  = 0;
  int t0      = 0;
  logic [7:0] exp_q [$];
  int b_ferr, b_ovr, b_vhi, b_rise;

  task automatic chk(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic snap();
    b_ferr = ferr_cnt;
    b_ovr  = ovr_cnt;
    b_vhi  = vhi_cnt;
    b_rise = rise_cnt;
  endtask

  task automatic drain(input string name);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_rd < got_wr) begin
        chk({name, "_byte"}, int'(got_mem[got_rd % 64]), int'(e));
        got_rd = got_rd + 1;
      end else begin
        chk({name, "_missing"}, -1, int'(e));
      end
    end
    chk({name, "_extra"}, got_wr - got_rd, 0);
    got_rd = got_wr;
  endtask

  // Drives one 8N1 frame, LSB first; called and returns on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bpc);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      if (i == 0) t0 = cyc + 1;
      repeat (bpc) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         baud;
    int         lat;
    int         pulses;
    int         ferrs;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, baud: 9, lat: 98, pulses: 1, ferrs: 0};
    vecs[1] = '{data: 8'h3C, stop_ok: 1'b1, baud: 5, lat: 60, pulses: 1, ferrs: 0};
    vecs[2] = '{data: 8'h01, stop_ok: 1'b1, baud: 4, lat: 51, pulses: 1, ferrs: 0};
    vecs[3] = '{data: 8'hC3, stop_ok: 1'b0, baud: 3, lat: 0,  pulses: 0, ferrs: 1};
    vecs[4] = '{data: 8'h80, stop_ok: 1'b1, baud: 3, lat: 41, pulses: 1, ferrs: 0};

    rst_n = 1'b0;
    serial_in = 1'b1;
    baud = BB'(9);
    rx_if.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(rx_busy), 0);
    chk("reset_valid", int'(rx_if.data_out_valid), 0);
    chk("reset_data", int'(rx_if.data_out), 0);
    chk("reset_ferr", int'(ferr), 0);
    chk("reset_ovr", int'(ovr), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frames from the table
    foreach (vecs[k]) begin
      baud = BB'(vecs[k].baud);
      snap();
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].baud + 1);
      if (vecs[k].stop_ok) exp_q.push_back(vecs[k].data);
      serial_in = 1'b1;
      repeat (2 * (vecs[k].baud + 1) + 10) @(negedge clk);
      chk($sformatf("vec%0d_pulses", k), rise_cnt - b_rise, vecs[k].pulses);
      chk($sformatf("vec%0d_valid_cycles", k), vhi_cnt - b_vhi, vecs[k].pulses);
      chk($sformatf("vec%0d_ferr", k), ferr_cnt - b_ferr, vecs[k].ferrs);
      chk($sformatf("vec%0d_ovr", k), ovr_cnt - b_ovr, 0);
      chk($sformatf("vec%0d_busy", k), int'(rx_busy), 0);
      if (vecs[k].pulses > 0)
        chk($sformatf("vec%0d_latency", k), rise_cyc - t0, vecs[k].lat);
      drain($sformatf("vec%0d", k));
    end

    // Start glitch: low for 3 clocks only
    baud = BB'(9);
    snap();
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_pulses", rise_cnt - b_rise, 0);
    chk("glitch_ferr", ferr_cnt - b_ferr, 0);
    chk("glitch_busy", int'(rx_busy), 0);

    // Bad stop bit followed by a held break
    snap();
    send_frame(8'h3C, 1'b0, 10);
    repeat (40) @(negedge clk);
    chk("break_busy_low_line", int'(rx_busy), 1);
    chk("break_ferr_once", ferr_cnt - b_ferr, 1);
    serial_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_busy_released", int'(rx_busy), 0);
    chk("break_pulses", rise_cnt - b_rise, 0);
    chk("break_ferr_total", ferr_cnt - b_ferr, 1);

    // Overrun: consumer stalled across two back-to-back frames
    rx_if.data_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    snap();
    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    exp_q.push_back(8'h11);
    repeat (20) @(negedge clk);
    chk("ovr_valid_held", int'(rx_if.data_out_valid), 1);
    chk("ovr_data_held", int'(rx_if.data_out), 8'h11);
    chk("ovr_pulse", ovr_cnt - b_ovr, 1);
    chk("ovr_ferr", ferr_cnt - b_ferr, 0);
    rx_if.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_consumed", int'(rx_if.data_out_valid), 0);
    chk("ovr_data_kept", int'(rx_if.data_out), 8'h11);
    chk("ovr_pulses", rise_cnt - b_rise, 1);
    drain("ovr");

    // Back-to-back stream at the fastest divisor
    baud = BB'(3);
    snap();
    send_frame(8'h00, 1'b1, 4);
    exp_q.push_back(8'h00);
    send_frame(8'hFF, 1'b1, 4);
    exp_q.push_back(8'hFF);
    send_frame(8'h55, 1'b1, 4);
    exp_q.push_back(8'h55);
    repeat (15) @(negedge clk);
    chk("stream_pulses", rise_cnt - b_rise, 3);
    chk("stream_valid_cycles", vhi_cnt - b_vhi, 3);
    chk("stream_ferr", ferr_cnt - b_ferr, 0);
    chk("stream_ovr", ovr_cnt - b_ovr, 0);
    drain("stream");

    // Asynchronous reset in the middle of a data bit
    baud = BB'(9);
    snap();
    serial_in = 1'b0;
    repeat (10) @(negedge clk);
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", int'(rx_busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", int'(rx_busy), 0);
    chk("rst_async_data", int'(rx_if.data_out), 0);
    chk("rst_async_valid", int'(rx_if.data_out_valid), 0);
    @(negedge clk);
    serial_in = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1, 10);
    exp_q.push_back(8'h7E);
    repeat (30) @(negedge clk);
    chk("rst_pulses", rise_cnt - b_rise, 1);
    chk("rst_ferr", ferr_cnt - b_ferr, 0);
    chk("rst_latency", rise_cyc - t0, 98);
    drain("rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Receive side of the UART link. It deserializes 8N1 frames from `serial_in` into bytes, using the same run-time `baud_edge` divisor that drives uart_transmitter. Each received byte is presented on a valid/ready interface to the core. The block sits in the io directory between the pad and the memory-mapped UART registers, and flags framing errors and overruns.

Parameters:
CLOCK_FREQ, 125_000_000, system clock frequency in Hz
MIN_BDRT, 9_600, slowest supported baud rate
BAUD_BITS, $clog2((CLOCK_FREQ+(MIN_BDRT/2)-1)/(MIN_BDRT/2)), width of the baud divisor and internal clock counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
baud_edge  input  BAUD_BITS  clocks per bit minus 1; must be >= 3 and stable while rx_busy=1
serial_in  input  1  asynchronous UART line, idle high
data_out  output  8  received byte
data_out_valid  output  1  data_out holds an unconsumed byte
data_out_ready  input  1  consumer accepts the byte when valid&ready
rx_busy  output  1  high in every state except IDLE
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good byte dropped because the holding register was full

Behaviour:
- Reset: one clock, reset is asynchronous and active-low (`clk`, `reset_n`). Reset forces all state immediately: synchronizer flops=1, state=IDLE, counters=0, data_out=8'h00, data_out_valid=0, framing_error=0, overrun=0, rx_busy=0. Reset mid-frame discards the partial byte.
- Synchronizer: serial_in passes through 2 flops to give rx_s. All decisions use rx_s only.
- Clock counter (BAUD_BITS wide): held at 0 in IDLE. Otherwise it increments each cycle and wraps to 0 on the state-specific compare value.
- half = baud_edge >> 1.
- IDLE: if rx_s==0, go to START with counter=0.
- START: when counter==half, the line is sampled at the start-bit midpoint.
  - rx_s==1: glitch; go to IDLE with no outputs.
  - rx_s==0: go to DATA with counter=0 and bit_cnt=0.
- DATA: when counter==baud_edge, shift rx_s into shift_reg[7] (right shift, LSB first), set counter=0, bit_cnt++. After the 8th sample (bit_cnt==7), go to STOP.
- STOP: when counter==baud_edge, sample the stop bit.
  - rx_s==1: deliver shift_reg; go to IDLE.
  - rx_s==0: pulse framing_error, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held break therefore produces exactly one framing_error.
- Delivery rules for the holding register:
  - If data_out_valid==0, or valid&ready in the same cycle: data_out<=shift_reg and data_out_valid<=1 on the cycle after the stop sample.
  - If valid==1 and ready==0: keep the old byte, pulse overrun, leave valid at 1.
- Consume: valid&ready with no delivery that cycle clears valid the next cycle. data_out is not cleared.
- Latency: T0 is the first clk edge at which serial_in is sampled low. With baud_edge=B, data_out_valid rises at edge T0 + 2 + (half+1) + 9*(B+1) + 1. For B=9 this is T0+98.
- Both the start sample and the data samples fall at mid-bit. Frames can be back-to-back: the next start edge is detected in the first IDLE cycle after the stop sample.

Test Plan:
- Reset, baud_edge=9, send 0xA5 (10 clocks/bit), ready=1 -> data_out=0xA5, valid high for exactly 1 cycle at T0+98, no error pulses.
- serial_in low for 3 clocks, then high -> returns to IDLE from START; no valid, framing_error=0.
- Send 0x3C with the stop bit forced low, then hold the line low for 40 clocks -> one framing_error pulse, no valid, rx_busy stays 1 until the line returns high.
- ready=0; send 0x11 then 0x22 back-to-back -> data_out=0x11 stays valid, one overrun pulse at the 0x22 stop sample; after ready=1, 0x11 is consumed and valid drops.
- ready=1; stream 0x00, 0xFF, 0x55 back-to-back at baud_edge=3 -> three valid pulses with the correct bytes in order, no errors.
- Assert reset_n=0 mid-DATA of 0x81, release, then send 0x7E -> outputs return to reset values asynchronously; only 0x7E is delivered.
